// File: rtl/rv32_wb_pkg.sv
// Shared types and constants for the RV32I register write-back path.
package rv32_wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_LINK = 2'd2,
    WB_RSVD = 2'd3
  } wb_kind_t;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [WB_SEL_W-1:0]  dst;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Load data formatter: selects the addressed byte/halfword of a memory word and extends it.
module wb_load_align
  import rv32_wb_pkg::*;
(
  input  logic [2:0]           funct3,
  input  logic [1:0]           off,
  input  logic [WB_DATA_W-1:0] word,
  output logic [WB_DATA_W-1:0] result
);

  logic [WB_DATA_W-1:0] byte_shift;
  logic [WB_DATA_W-1:0] half_shift;

  assign byte_shift = word >> {off, 3'b000};
  assign half_shift = word >> {off[1], 4'b0000};

  // NOTE: result is assigned on every path (default arm included), so no latch is inferred.
  always_comb begin
    case (funct3)
      F3_LB:   result = {{24{byte_shift[7]}}, byte_shift[7:0]};
      F3_LBU:  result = {24'b0, byte_shift[7:0]};
      F3_LH:   result = {{16{half_shift[15]}}, half_shift[15:0]};
      F3_LHU:  result = {16'b0, half_shift[15:0]};
      F3_LW:   result = word;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Register-file write driver: formats results, queues them, issues one write per cycle, tracks busy regs.
// Optional WB_BYPASS_EN adds two combinational forwarding ports fed from the queued writes.
module reg_writeback_unit
  import rv32_wb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SELECT_SIZE = 5,
  parameter int DEPTH       = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   res_valid_i,
  output logic                   res_ready_o,
  input  logic [1:0]             res_kind_i,
  input  logic [2:0]             res_funct3_i,
  input  logic [1:0]             res_byte_off_i,
  input  logic [DATA_WIDTH-1:0]  res_data_i,
  input  logic [SELECT_SIZE-1:0] res_dst_i,
  input  logic                   flush_i,
  output logic                   reg_we_no,
  output logic [DATA_WIDTH-1:0]  reg_data_o,
  output logic [SELECT_SIZE-1:0] reg_dst_o,
  output logic [31:0]            busy_o
`ifdef WB_BYPASS_EN
  ,
  input  logic [SELECT_SIZE-1:0] byp_srcA_i,
  input  logic [SELECT_SIZE-1:0] byp_srcB_i,
  output logic                   byp_hitA_o,
  output logic                   byp_hitB_o,
  output logic [DATA_WIDTH-1:0]  byp_dataA_o,
  output logic [DATA_WIDTH-1:0]  byp_dataB_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_kind_t              res_kind;
  wb_entry_t             fifo_q [DEPTH];
  wb_entry_t             enq_entry;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [DATA_WIDTH-1:0] load_word;
  logic [DEPTH-1:0]      entry_live;
  logic                  accept;
  logic                  push;
  logic                  pop;

  assign res_kind    = wb_kind_t'(res_kind_i);
  assign res_ready_o = reset_ni && (count_q < CNT_W'(DEPTH));
  assign accept      = res_valid_i && res_ready_o;
  // x0 and reserved results complete the handshake but never reach the register file
  assign push        = accept && !flush_i && (res_dst_i != '0) && (res_kind != WB_RSVD);
  assign pop         = (count_q != '0) && !flush_i;

  wb_load_align u_load_align (
    .funct3 (res_funct3_i),
    .off    (res_byte_off_i),
    .word   (res_data_i),
    .result (load_word)
  );

  assign enq_entry.data = (res_kind == WB_LOAD) ? load_word : res_data_i;
  assign enq_entry.dst  = res_dst_i;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      reg_we_no  <= 1'b1;
      reg_data_o <= '0;
      reg_dst_o  <= '0;
    end else if (flush_i) begin
      // the write already on the output stage committed at the preceding negedge
      rd_ptr_q  <= wr_ptr_q;
      count_q   <= '0;
      reg_we_no <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q   <= count_q + CNT_W'(push) - CNT_W'(pop);
      reg_we_no <= !pop;
      if (pop) begin
        reg_data_o <= fifo_q[rd_ptr_q].data;
        reg_dst_o  <= fifo_q[rd_ptr_q].dst;
      end
    end
  end

  // NOTE: no reset on the storage array; count and pointers alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= enq_entry;
  end

  always_comb begin
    entry_live = '0;
    for (int i = 0; i < DEPTH; i++)
      entry_live[i] = CNT_W'(PTR_W'(i) - rd_ptr_q) < count_q;
  end

  always_comb begin
    busy_o = '0;
    if (!reg_we_no) busy_o[reg_dst_o] = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      if (entry_live[i]) busy_o[fifo_q[i].dst] = 1'b1;
  end

`ifdef WB_BYPASS_EN
  // Scans oldest (output stage) to youngest (FIFO tail) so the youngest match is kept.
  function automatic logic [DATA_WIDTH:0] byp_lookup(input logic [SELECT_SIZE-1:0] src);
    logic [DATA_WIDTH:0] r;
    logic [PTR_W-1:0]    idx;
    r   = '0;
    idx = '0;
    if (src != '0) begin
      if (!reg_we_no && reg_dst_o == src) r = {1'b1, reg_data_o};
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr_q + PTR_W'(k);
        if (entry_live[idx] && fifo_q[idx].dst == src) r = {1'b1, fifo_q[idx].data};
      end
    end
    return r;
  endfunction

  always_comb begin
    {byp_hitA_o, byp_dataA_o} = byp_lookup(byp_srcA_i);
    {byp_hitB_o, byp_dataB_o} = byp_lookup(byp_srcB_i);
  end
`endif

endmodule
